// File: rtl/ps2_pkg.sv
// Shared constants, types and helpers for the PS/2 to Z88 key-matrix front end.
package ps2_pkg;

    localparam int unsigned KBMAT_W    = 64;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned BIT_CNT_W  = 4;

    localparam logic [7:0] SC_E0      = 8'hE0;
    localparam logic [7:0] SC_F0      = 8'hF0;
    localparam logic [7:0] SC_BAT     = 8'hAA;
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_ECHO    = 8'hEE;
    localparam logic [7:0] SC_RESEND  = 8'hFE;
    localparam logic [7:0] SC_OVF_LO  = 8'h00;
    localparam logic [7:0] SC_OVF_HI  = 8'hFF;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_CHECK
    } rx_state_e;

    // Frame as it sits in the shift register once all ten post-start bits are in.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    function automatic logic [IDX_W-1:0] kb_idx(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/ps2_scan_map.sv
// Set-2 scan code (with E0 extension) to Z88 matrix index lookup; combinational.
module ps2_scan_map
    import ps2_pkg::*;
(
    input  logic             ext_i,
    input  logic [7:0]       code_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    logic       hit;
    logic [2:0] row;
    logic [2:0] col;

    always_comb begin
        hit = 1'b0;
        row = 3'd0;
        col = 3'd0;
        case ({ext_i, code_i})
            9'h03E: {hit, row, col} = {1'b1, 3'd0, 3'd0}; // 8
            9'h03D: {hit, row, col} = {1'b1, 3'd0, 3'd1}; // 7
            9'h031: {hit, row, col} = {1'b1, 3'd0, 3'd2}; // N
            9'h033: {hit, row, col} = {1'b1, 3'd0, 3'd3}; // H
            9'h035: {hit, row, col} = {1'b1, 3'd0, 3'd4}; // Y
            9'h036: {hit, row, col} = {1'b1, 3'd0, 3'd5}; // 6
            9'h05A: {hit, row, col} = {1'b1, 3'd0, 3'd6}; // Enter
            9'h066: {hit, row, col} = {1'b1, 3'd0, 3'd7}; // Backspace -> DEL
            9'h043: {hit, row, col} = {1'b1, 3'd1, 3'd0}; // I
            9'h03C: {hit, row, col} = {1'b1, 3'd1, 3'd1}; // U
            9'h032: {hit, row, col} = {1'b1, 3'd1, 3'd2}; // B
            9'h034: {hit, row, col} = {1'b1, 3'd1, 3'd3}; // G
            9'h02C: {hit, row, col} = {1'b1, 3'd1, 3'd4}; // T
            9'h02E: {hit, row, col} = {1'b1, 3'd1, 3'd5}; // 5
            9'h175: {hit, row, col} = {1'b1, 3'd1, 3'd6}; // Up
            9'h05D: {hit, row, col} = {1'b1, 3'd1, 3'd7}; // backslash
            9'h044: {hit, row, col} = {1'b1, 3'd2, 3'd0}; // O
            9'h03B: {hit, row, col} = {1'b1, 3'd2, 3'd1}; // J
            9'h02A: {hit, row, col} = {1'b1, 3'd2, 3'd2}; // V
            9'h02B: {hit, row, col} = {1'b1, 3'd2, 3'd3}; // F
            9'h02D: {hit, row, col} = {1'b1, 3'd2, 3'd4}; // R
            9'h025: {hit, row, col} = {1'b1, 3'd2, 3'd5}; // 4
            9'h172: {hit, row, col} = {1'b1, 3'd2, 3'd6}; // Down
            9'h055: {hit, row, col} = {1'b1, 3'd2, 3'd7}; // =
            9'h046: {hit, row, col} = {1'b1, 3'd3, 3'd0}; // 9
            9'h042: {hit, row, col} = {1'b1, 3'd3, 3'd1}; // K
            9'h021: {hit, row, col} = {1'b1, 3'd3, 3'd2}; // C
            9'h023: {hit, row, col} = {1'b1, 3'd3, 3'd3}; // D
            9'h024: {hit, row, col} = {1'b1, 3'd3, 3'd4}; // E
            9'h026: {hit, row, col} = {1'b1, 3'd3, 3'd5}; // 3
            9'h174: {hit, row, col} = {1'b1, 3'd3, 3'd6}; // Right
            9'h04E: {hit, row, col} = {1'b1, 3'd3, 3'd7}; // -
            9'h04D: {hit, row, col} = {1'b1, 3'd4, 3'd0}; // P
            9'h03A: {hit, row, col} = {1'b1, 3'd4, 3'd1}; // M
            9'h022: {hit, row, col} = {1'b1, 3'd4, 3'd2}; // X
            9'h01B: {hit, row, col} = {1'b1, 3'd4, 3'd3}; // S
            9'h01D: {hit, row, col} = {1'b1, 3'd4, 3'd4}; // W
            9'h01E: {hit, row, col} = {1'b1, 3'd4, 3'd5}; // 2
            9'h16B: {hit, row, col} = {1'b1, 3'd4, 3'd6}; // Left
            9'h05B: {hit, row, col} = {1'b1, 3'd4, 3'd7}; // ]
            9'h045: {hit, row, col} = {1'b1, 3'd5, 3'd0}; // 0
            9'h04B: {hit, row, col} = {1'b1, 3'd5, 3'd1}; // L
            9'h01A: {hit, row, col} = {1'b1, 3'd5, 3'd2}; // Z
            9'h01C: {hit, row, col} = {1'b1, 3'd5, 3'd3}; // A
            9'h015: {hit, row, col} = {1'b1, 3'd5, 3'd4}; // Q
            9'h016: {hit, row, col} = {1'b1, 3'd5, 3'd5}; // 1
            9'h059: {hit, row, col} = {1'b1, 3'd5, 3'd6}; // Right shift
            9'h054: {hit, row, col} = {1'b1, 3'd5, 3'd7}; // [
            9'h052: {hit, row, col} = {1'b1, 3'd6, 3'd0}; // '
            9'h04C: {hit, row, col} = {1'b1, 3'd6, 3'd1}; // ;
            9'h041: {hit, row, col} = {1'b1, 3'd6, 3'd2}; // ,
            9'h005: {hit, row, col} = {1'b1, 3'd6, 3'd3}; // F1 -> MENU
            9'h00D: {hit, row, col} = {1'b1, 3'd6, 3'd4}; // Tab
            9'h029: {hit, row, col} = {1'b1, 3'd6, 3'd5}; // Space
            9'h076: {hit, row, col} = {1'b1, 3'd6, 3'd7}; // Esc
            9'h049: {hit, row, col} = {1'b1, 3'd7, 3'd0}; // .
            9'h04A: {hit, row, col} = {1'b1, 3'd7, 3'd1}; // /
            9'h00E: {hit, row, col} = {1'b1, 3'd7, 3'd2}; // backtick -> pound
            9'h006: {hit, row, col} = {1'b1, 3'd7, 3'd3}; // F2 -> INDEX
            9'h058: {hit, row, col} = {1'b1, 3'd7, 3'd4}; // Caps lock
            9'h014: {hit, row, col} = {1'b1, 3'd7, 3'd5}; // Ctrl -> diamond
            9'h012: {hit, row, col} = {1'b1, 3'd7, 3'd6}; // Left shift
            9'h004: {hit, row, col} = {1'b1, 3'd7, 3'd7}; // F3 -> HELP
            default: {hit, row, col} = {1'b0, 3'd0, 3'd0};
        endcase
    end

    assign hit_o = hit;
    assign idx_o = kb_idx(row, col);

endmodule

// File: rtl/ps2_keymat.sv
// PS/2 keyboard receiver and Set-2 decoder driving the active-low Z88 key matrix.
module ps2_keymat
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ps2clk,
    input  logic               ps2dat,
    output logic [KBMAT_W-1:0] kbmat_out,
    output logic               code_valid,
    output logic [7:0]         code,
    output logic               frame_err
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             flt_clk_q, flt_clk_d;
    logic             fall_q;
    logic             dat_smp_q;

    rx_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    ps2_frame_t           frame_q, frame_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 e0_q, e0_d;
    logic                 f0_q, f0_d;
    logic [KBMAT_W-1:0]   kbmat_q, kbmat_d;
    logic [7:0]           code_q, code_d;
    logic                 code_valid_q, code_valid_d;
    logic                 frame_err_q, frame_err_d;

    logic             map_hit;
    logic [IDX_W-1:0] map_idx;
    logic             frame_ok;

    // Level change accepted only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        flt_cnt_d = '0;
        flt_clk_d = flt_clk_q;
        if (clk_sync_q[1] != flt_clk_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                flt_clk_d = clk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            flt_cnt_q  <= '0;
            flt_clk_q  <= 1'b1;
            fall_q     <= 1'b0;
            dat_smp_q  <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2clk};
            dat_sync_q <= {dat_sync_q[0], ps2dat};
            flt_cnt_q  <= flt_cnt_d;
            flt_clk_q  <= flt_clk_d;
            fall_q     <= flt_clk_q & ~flt_clk_d;
            dat_smp_q  <= dat_sync_q[1];
        end
    end

    ps2_scan_map u_map (
        .ext_i  (e0_q),
        .code_i (frame_q.data),
        .hit_o  (map_hit),
        .idx_o  (map_idx)
    );

    assign frame_ok = (^{frame_q.data, frame_q.parity}) & frame_q.stop;

    // Receiver FSM plus decoder; the decode happens in CHECK so that the matrix
    // and code_valid land on the same edge.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        frame_d      = frame_q;
        to_cnt_d     = to_cnt_q;
        e0_d         = e0_q;
        f0_d         = f0_q;
        kbmat_d      = kbmat_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                bit_cnt_d = '0;
                to_cnt_d  = '0;
                if (fall_q) begin
                    if (!dat_smp_q) begin
                        state_d = RX_SHIFT;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            RX_SHIFT: begin
                if (fall_q) begin
                    frame_d  = ps2_frame_t'({dat_smp_q, frame_q[FRAME_BITS-1:1]});
                    to_cnt_d = '0;
                    if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = RX_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    state_d   = RX_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            RX_CHECK: begin
                state_d = RX_IDLE;
                if (frame_ok) begin
                    code_valid_d = 1'b1;
                    code_d       = frame_q.data;
                    case (frame_q.data)
                        SC_E0: e0_d = 1'b1;
                        SC_F0: f0_d = 1'b1;
                        SC_BAT, SC_ACK, SC_ECHO, SC_RESEND: begin
                        end
                        SC_OVF_LO, SC_OVF_HI: begin
                            kbmat_d = '1;
                            e0_d    = 1'b0;
                            f0_d    = 1'b0;
                        end
                        default: begin
                            if (map_hit) begin
                                kbmat_d[map_idx] = f0_q;
                            end
                            e0_d = 1'b0;
                            f0_d = 1'b0;
                        end
                    endcase
                end else begin
                    frame_err_d = 1'b1;
                    e0_d        = 1'b0;
                    f0_d        = 1'b0;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= RX_IDLE;
            bit_cnt_q    <= '0;
            frame_q      <= '0;
            to_cnt_q     <= '0;
            e0_q         <= 1'b0;
            f0_q         <= 1'b0;
            kbmat_q      <= '1;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_q      <= frame_d;
            to_cnt_q     <= to_cnt_d;
            e0_q         <= e0_d;
            f0_q         <= f0_d;
            kbmat_q      <= kbmat_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign kbmat_out  = kbmat_q;
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keymat.sv
// Self-checking bench for ps2_keymat: directed scenarios plus random byte streams.
module tb_ps2_keymat;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 20000;
    localparam int HALF           = 25;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2clk = 1'b1;
    logic        ps2dat = 1'b1;
    logic [63:0] kbmat_out;
    logic        code_valid;
    logic [7:0]  code;
    logic        frame_err;

    ps2_keymat #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2clk     (ps2clk),
        .ps2dat     (ps2dat),
        .kbmat_out  (kbmat_out),
        .code_valid (code_valid),
        .code       (code),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int cv_cyc = 0;
    int stop_cyc = 0;
    logic [7:0] cv_code = 8'h00;

    // Behavioural model of the key matrix and prefix flags.
    logic [63:0] m_kb = '1;
    bit          m_e0 = 1'b0;
    bit          m_f0 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (code_valid) begin
            cv_cnt  <= cv_cnt + 1;
            cv_code <= code;
            cv_cyc  <= cyc;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int map_idx(input bit ext, input logic [7:0] b);
        if (!ext && b == 8'h1C) return 43;
        if (!ext && b == 8'h5A) return 6;
        if (!ext && b == 8'h12) return 62;
        if (!ext && b == 8'h29) return 53;
        if (ext && b == 8'h75)  return 14;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int i;
        if (b == 8'hE0) m_e0 = 1'b1;
        else if (b == 8'hF0) m_f0 = 1'b1;
        else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) begin
        end else if (b == 8'h00 || b == 8'hFF) begin
            m_kb = '1;
            m_e0 = 1'b0;
            m_f0 = 1'b0;
        end else begin
            i = map_idx(m_e0, b);
            if (i >= 0) m_kb[i] = m_f0;
            m_e0 = 1'b0;
            m_f0 = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_kb = '1;
        m_e0 = 1'b0;
        m_f0 = 1'b0;
    endtask

    // Drives the first n bits of f, LSB first; data changes while clock is high.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2dat = f[i];
            repeat (HALF) @(negedge clk);
            ps2clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2clk = 1'b1;
        end
        ps2dat = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    // err: 0 good frame, 1 parity error, 2 stop error
    task automatic do_frame(input logic [7:0] b, input int err);
        int cv0;
        int fe0;
        int lat;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_bits(make_frame(b, err == 1, err == 2), 11);
        repeat (2 * HALF) @(negedge clk);
        if (err == 0) begin
            model_byte(b);
            check_eq("cv_count", 64'(cv_cnt - cv0), 64'd1);
            check_eq("code", 64'(cv_code), 64'(b));
            lat = cv_cyc - stop_cyc;
            check_eq("latency_window", 64'(lat >= FILTER_LEN + 2 && lat <= FILTER_LEN + 6), 64'd1);
            check_eq("no_ferr", 64'(fe_cnt - fe0), 64'd0);
        end else begin
            m_e0 = 1'b0;
            m_f0 = 1'b0;
            check_eq("ferr_count", 64'(fe_cnt - fe0), 64'd1);
            check_eq("no_cv_on_err", 64'(cv_cnt - cv0), 64'd0);
        end
        check_eq("kbmat", kbmat_out, m_kb);
    endtask

    logic [7:0] pool [18] = '{8'h1C, 8'h5A, 8'h12, 8'h29, 8'h75, 8'h75, 8'h1C, 8'h29,
                              8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'hEE,
                              8'hFE, 8'h00};

    initial begin
        int fe0;
        int cv0;
        logic [7:0] b;
        int err;

        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_kbmat", kbmat_out, '1);
        check_eq("rst_code", 64'(code), 64'h0);
        check_eq("rst_cv", 64'(code_valid), 64'h0);
        check_eq("rst_ferr", 64'(frame_err), 64'h0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // make A
        do_frame(8'h1C, 0);
        check_eq("kb_A_only", kbmat_out, ~(64'h1 << 43));
        // break A
        do_frame(8'hF0, 0);
        check_eq("kb_after_F0", kbmat_out, ~(64'h1 << 43));
        do_frame(8'h1C, 0);
        check_eq("kb_A_break", 64'(kbmat_out[43]), 64'd1);

        // extended up arrow make/break, then plain 0x75 miss
        do_frame(8'hE0, 0);
        do_frame(8'h75, 0);
        check_eq("kb_up_make", 64'(kbmat_out[14]), 64'd0);
        do_frame(8'hE0, 0);
        do_frame(8'hF0, 0);
        do_frame(8'h75, 0);
        check_eq("kb_up_break", kbmat_out, '1);
        do_frame(8'h75, 0);

        // bad parity, then flags cleared by a rejected frame
        do_frame(8'h5A, 1);
        do_frame(8'hF0, 0);
        do_frame(8'h33, 1);
        do_frame(8'h5A, 0);
        check_eq("kb_enter_make", 64'(kbmat_out[6]), 64'd0);
        do_frame(8'h44, 2);

        // partial frame abandoned by timeout
        fe0 = fe_cnt;
        cv0 = cv_cnt;
        send_bits(make_frame(8'hA5, 1'b0, 1'b0), 5);
        repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
        check_eq("timeout_no_ferr", 64'(fe_cnt - fe0), 64'd0);
        check_eq("timeout_no_cv", 64'(cv_cnt - cv0), 64'd0);
        do_frame(8'h29, 0);
        check_eq("kb_space_make", 64'(kbmat_out[53]), 64'd0);

        // overflow clears the matrix
        do_frame(8'h12, 0);
        do_frame(8'h1C, 0);
        check_eq("kb_two_held", 64'({kbmat_out[62], kbmat_out[43]}), 64'd0);
        do_frame(8'h00, 0);
        check_eq("kb_overflow", kbmat_out, '1);

        // reset mid-frame
        do_frame(8'h12, 0);
        do_frame(8'hE0, 0);
        send_bits(make_frame(8'h1C, 1'b0, 1'b0), 4);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_kbmat", kbmat_out, '1);
        check_eq("midrst_code", 64'(code), 64'h0);
        check_eq("midrst_cv", 64'(code_valid), 64'h0);
        check_eq("midrst_ferr", 64'(frame_err), 64'h0);
        reset_n = 1'b1;
        model_reset();
        repeat (2 * HALF) @(negedge clk);
        do_frame(8'h1C, 0);
        check_eq("kb_A_after_rst", kbmat_out, ~(64'h1 << 43));

        // random stream against the model
        for (int n = 0; n < 50; n++) begin
            b = pool[$urandom_range(0, 17)];
            if ($urandom_range(0, 19) == 0) b = 8'hFF;
            err = 0;
            if ($urandom_range(0, 7) == 0) err = int'($urandom_range(1, 2));
            do_frame(b, err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_keymat.md
Name: ps2_keymat

Overview:
- Upstream stage of the Blink keyboard input: converts a PS/2 keyboard serial stream into the 64-bit Z88 key matrix (kbmat) that the Blink samples during row scans.
- Contains three parts: a PS/2 frame receiver, a Set-2 make/break decoder with E0/F0 prefix tracking, and a registered key-state matrix.
- Runs entirely on the master clock; the asynchronous PS/2 lines are synchronised inside the block.

Parameters:
- FILTER_LEN, 4, number of consecutive identical synchronised ps2clk samples required before a level change is accepted.
- TIMEOUT_CYCLES, 20000, idle clk cycles after which a partial frame is discarded (about 200 us at 100 MHz; must exceed 2x the PS/2 bit period).

Ports:
- clk  in  1  master clock.
- reset_n  in  1  synchronous reset, active-low.
- ps2clk  in  1  PS/2 clock, asynchronous, idle high.
- ps2dat  in  1  PS/2 data, asynchronous, idle high.
- kbmat_out  out  64  key matrix, bit index = row*8+col, active-low (0 = key pressed).
- code_valid  out  1  one-cycle strobe for each accepted data byte.
- code  out  8  last accepted byte, held until the next code_valid.
- frame_err  out  1  one-cycle strobe on start, parity or stop error.

Behaviour:
- Reset: everything resets synchronously on the clk edge with reset_n=0.
  - kbmat_out = all ones; code = 0x00; code_valid = 0; frame_err = 0.
  - Receiver returns to IDLE with the bit counter at 0; E0 and F0 flags are cleared.
  - Reset asserted mid-frame discards the frame. Reset has priority over every other event.
- Synchronisation:
  - ps2clk and ps2dat each pass through a 2-FF synchroniser.
  - ps2clk is then glitch-filtered (FILTER_LEN samples).
  - A falling edge is detected on the filtered clock. ps2dat is sampled on that edge.
- Receiver FSM, states IDLE, SHIFT, CHECK:
  - IDLE: a falling edge with dat=0 captures the start bit and goes to SHIFT. A falling edge with dat=1 pulses frame_err and stays in IDLE.
  - SHIFT: captures 8 data bits LSB first, then the parity bit, then the stop bit (10 edges). After the stop edge it goes to CHECK.
  - CHECK (1 cycle): the frame is accepted if the data plus parity have odd parity and stop=1. Otherwise frame_err pulses. Always returns to IDLE.
  - Timeout: in SHIFT, TIMEOUT_CYCLES without a falling edge returns the FSM to IDLE silently, with no frame_err. The counter reloads on every falling edge.
- Latency: code_valid and code update on the cycle after CHECK, i.e. 2 clk cycles after the stop-bit edge is detected.
- Decoder, acting on an accepted byte B:
  - B=0xE0: set E0, no matrix change.
  - B=0xF0: set F0, no matrix change.
  - B in {0xAA, 0xFA, 0xEE, 0xFE}: ignored, flags unchanged.
  - B in {0x00, 0xFF} (overflow): kbmat_out set to all ones, flags cleared.
  - Otherwise: look up {E0, B} in the map.
    - Hit at index i: bit i is cleared if F0=0 (make) or set if F0=1 (break).
    - Miss: no matrix change.
    - E0 and F0 are cleared in both cases.
  - A rejected frame also clears E0 and F0.
  - kbmat_out updates in the same cycle as code_valid.
- Typematic repeats (repeated make codes) leave an already-cleared bit cleared.
- Two keys mapping to the same index: the last event wins.
- Other matrix bits are never disturbed by a single event.

Decomposition:
- Shared package ps2_pkg holds:
  - Scan-code constants: SC_E0=0xE0, SC_F0=0xF0, SC_BAT=0xAA, SC_ACK=0xFA, SC_ECHO=0xEE, SC_RESEND=0xFE.
  - KBMAT_W=64 and the index encoding helper.
- Sub-module ps2_scan_map: purely combinational.
  - Inputs: ext (1), code (8).
  - Outputs: hit (1), idx (6).
  - Required entries include:
    - 0x1C (A) -> 43
    - 0x5A (Enter) -> 6
    - 0x12 (left shift) -> 62
    - E0+0x75 (up arrow) -> 14
    - 0x29 (space) -> 53

Test Plan:
- Frame 0x1C with odd parity 0 and stop 1 -> code_valid 2 cycles after the stop edge, code=0x1C, kbmat_out[43]=0, all other bits 1.
- Sequence 1C, F0 1C -> bit 43 is 0 after the first byte and 1 after the break; no code_valid pulse marks a matrix change for the F0 byte itself.
- E0 75 then E0 F0 75 -> bit 14 clears and then sets. A plain 0x75 (no E0) leaves the matrix unchanged, since it is a miss.
- Frame 0x5A with bad parity -> frame_err pulse, no code_valid, kbmat unchanged. Following that, F0 (good) then a bad frame then 0x5A (good) -> bit 6 clears, because the flags were cleared by the rejected frame.
- 5 bits sent then the line is idle for TIMEOUT_CYCLES+10 -> no frame_err. A full 0x29 frame afterwards -> bit 53 clears.
- Keys 12 and 1C held, then byte 0x00 -> kbmat_out = all ones. reset_n low mid-frame -> all outputs at reset values the next cycle, and the next full frame decodes correctly.
